// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: two-flop synchroniser, mid-bit sampling FSM,
// optional parity check and a valid/ready output stage with error pulses.
module uart_rx_os #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 7,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data_out,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t               r_state;
   logic [1:0]           r_sync;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bad;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_parity_err;
   logic                 r_overrun;

   logic w_rx_s;
   logic w_bit_tick;

   assign w_rx_s = r_sync[1];
   // START waits half a bit to land mid-start-bit; every later sample is a full bit apart.
   assign w_bit_tick = (r_state == S_START) ? (r_cnt == HALF_LAST) : (r_cnt == FULL_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_sync       <= 2'b11;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_par_bad    <= 1'b0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_sync       <= {r_sync[0], rx_in};
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overrun    <= 1'b0;

         // A word delivered in this same cycle overrides this drop below.
         if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end

         if (r_state != S_IDLE && r_state != S_WAIT_IDLE) begin
            r_cnt <= w_bit_tick ? '0 : r_cnt + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (!w_rx_s) begin
                  r_state   <= S_START;
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_par_bad <= 1'b0;
               end
            end
            S_START: begin
               if (w_bit_tick) begin
                  r_state <= w_rx_s ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (w_bit_tick) begin
                  r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == LAST_BIT) begin
                     r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end
               end
            end
            S_PARITY: begin
               if (w_bit_tick) begin
                  r_par_bad <= ((^r_shift) ^ w_rx_s) != PAR_ODD;
                  r_state   <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_bit_tick) begin
                  if (!w_rx_s) begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_WAIT_IDLE;
                  end else if (r_par_bad) begin
                     r_parity_err <= 1'b1;
                     r_state      <= S_IDLE;
                  end else begin
                     r_data    <= r_shift;
                     r_valid   <= 1'b1;
                     r_overrun <= r_valid && !rx_ready;
                     r_state   <= S_IDLE;
                  end
               end
            end
            S_WAIT_IDLE: begin
               if (w_rx_s) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rx_data_out = r_data;
   assign rx_valid    = r_valid;
   assign frame_err   = r_frame_err;
   assign parity_err  = r_parity_err;
   assign overrun     = r_overrun;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: a default instance (7N1) and an odd-parity instance.
module tb_uart_rx_os;

   localparam int N = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       rx_a  = 1'b1;
   logic       rx_p  = 1'b1;
   logic       rdy_a = 1'b1;
   logic       rdy_p = 1'b1;

   logic [6:0] a_data, p_data;
   logic       a_valid, a_frame, a_par, a_ovr, a_busy;
   logic       p_valid, p_frame, p_par, p_ovr, p_busy;

   uart_rx_os #(.CLKS_PER_BIT(N), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_in      (rx_a),
      .rx_data_out(a_data),
      .rx_valid   (a_valid),
      .rx_ready   (rdy_a),
      .frame_err  (a_frame),
      .parity_err (a_par),
      .overrun    (a_ovr),
      .busy       (a_busy)
   );

   uart_rx_os #(.CLKS_PER_BIT(N), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_p (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_in      (rx_p),
      .rx_data_out(p_data),
      .rx_valid   (p_valid),
      .rx_ready   (rdy_p),
      .frame_err  (p_frame),
      .parity_err (p_par),
      .overrun    (p_ovr),
      .busy       (p_busy)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitors, sampled on the falling edge.
   int         a_rise_n = 0, a_rise_cyc = 0, a_valid_n = 0, a_frame_n = 0, a_frame_cyc = 0;
   int         a_par_n = 0, a_ovr_n = 0, a_ovr_cyc = 0;
   logic [6:0] a_rise_data = '0;
   logic       a_prev = 1'b0;
   int         p_rise_n = 0, p_rise_cyc = 0, p_frame_n = 0, p_par_n = 0, p_par_cyc = 0, p_ovr_n = 0;
   logic [6:0] p_rise_data = '0;
   logic       p_prev = 1'b0;

   always @(negedge clk) begin
      if (a_valid && !a_prev) begin
         a_rise_n    <= a_rise_n + 1;
         a_rise_cyc  <= cyc;
         a_rise_data <= a_data;
      end
      a_prev <= a_valid;
      if (a_valid) a_valid_n <= a_valid_n + 1;
      if (a_frame) begin
         a_frame_n   <= a_frame_n + 1;
         a_frame_cyc <= cyc;
      end
      if (a_par) a_par_n <= a_par_n + 1;
      if (a_ovr) begin
         a_ovr_n   <= a_ovr_n + 1;
         a_ovr_cyc <= cyc;
      end
      if (p_valid && !p_prev) begin
         p_rise_n    <= p_rise_n + 1;
         p_rise_cyc  <= cyc;
         p_rise_data <= p_data;
      end
      p_prev <= p_valid;
      if (p_frame) p_frame_n <= p_frame_n + 1;
      if (p_par) begin
         p_par_n   <= p_par_n + 1;
         p_par_cyc <= cyc;
      end
      if (p_ovr) p_ovr_n <= p_ovr_n + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Frame on the default line; fall is the cycle count when the start edge is driven.
   task automatic send_a(input logic [6:0] d, input logic stop, output int fall);
      fall = cyc;
      rx_a = 1'b0;
      tick(N);
      for (int i = 0; i < 7; i++) begin
         rx_a = d[i];
         tick(N);
      end
      rx_a = stop;
      tick(N);
      rx_a = 1'b1;
   endtask

   task automatic send_p(input logic [6:0] d, input logic pbit, input logic stop, output int fall);
      fall = cyc;
      rx_p = 1'b0;
      tick(N);
      for (int i = 0; i < 7; i++) begin
         rx_p = d[i];
         tick(N);
      end
      rx_p = pbit;
      tick(N);
      rx_p = stop;
      tick(N);
      rx_p = 1'b1;
   endtask

   typedef struct {
      logic [6:0] data;
      logic       stop;
      int         exp_valid;
      int         exp_frame;
   } vec_t;

   vec_t vecs[6];
   int   fall, f1, f2;
   int   s_rise, s_valid, s_frame, s_par, s_ovr;
   int   sp_rise, sp_frame, sp_par, sp_ovr;
   int   nhi, first_hi, nlow;

   task automatic snap();
      s_rise   = a_rise_n;
      s_valid  = a_valid_n;
      s_frame  = a_frame_n;
      s_par    = a_par_n;
      s_ovr    = a_ovr_n;
      sp_rise  = p_rise_n;
      sp_frame = p_frame_n;
      sp_par   = p_par_n;
      sp_ovr   = p_ovr_n;
   endtask

   initial begin
      vecs[0] = '{7'h5A, 1'b1, 1, 0};
      vecs[1] = '{7'h00, 1'b1, 1, 0};
      vecs[2] = '{7'h7F, 1'b1, 1, 0};
      vecs[3] = '{7'h2A, 1'b1, 1, 0};
      vecs[4] = '{7'h55, 1'b1, 1, 0};
      vecs[5] = '{7'h33, 1'b0, 0, 1};

      // Reset state of both instances
      rst_n = 1'b0;
      tick(4);
      chk("reset_a", int'({a_valid, a_frame, a_par, a_ovr, a_busy, a_data}), 0);
      chk("reset_p", int'({p_valid, p_frame, p_par, p_ovr, p_busy, p_data}), 0);
      rst_n = 1'b1;
      tick(5);

      // Table of single frames, rx_ready held high
      for (int i = 0; i < 6; i++) begin
         snap();
         send_a(vecs[i].data, vecs[i].stop, fall);
         tick(3 * N);
         $display("vec %0d: data=%h stop=%b valid_rises=%0d frame_errs=%0d", i, vecs[i].data,
                  vecs[i].stop, a_rise_n - s_rise, a_frame_n - s_frame);
         chk("vec_valid_rise", a_rise_n - s_rise, vecs[i].exp_valid);
         if (vecs[i].exp_valid != 0) begin
            chk("vec_latency", a_rise_cyc - fall, 139);
            chk("vec_data", int'(a_rise_data), int'(vecs[i].data));
            chk("vec_valid_cycles", a_valid_n - s_valid, 1);
         end
         chk("vec_frame_err", a_frame_n - s_frame, vecs[i].exp_frame);
         if (vecs[i].exp_frame != 0) chk("vec_frame_pos", a_frame_cyc - fall, 139);
         chk("vec_parity_err", a_par_n - s_par, 0);
         chk("vec_overrun", a_ovr_n - s_ovr, 0);
      end

      // Glitch: four low cycles must be rejected at the mid-start sample
      snap();
      fall     = cyc;
      nhi      = 0;
      first_hi = -1;
      rx_a     = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 4) rx_a = 1'b1;
         if (a_busy) begin
            nhi++;
            if (first_hi < 0) first_hi = cyc - fall;
         end
      end
      @(posedge clk);
      #1;
      $display("glitch: busy_cycles=%0d first=%0d", nhi, first_hi);
      chk("glitch_busy_cycles", nhi, 8);
      chk("glitch_busy_start", first_hi, 3);
      chk("glitch_no_valid", a_rise_n - s_rise, 0);
      chk("glitch_no_flags", (a_frame_n - s_frame) + (a_par_n - s_par) + (a_ovr_n - s_ovr), 0);

      // Framing error followed by a long break, then a good frame
      snap();
      send_a(7'h33, 1'b0, fall);
      rx_a = 1'b0;
      nlow = 0;
      for (int k = 0; k < 40 * N; k++) begin
         @(negedge clk);
         if (!a_busy) nlow++;
      end
      @(posedge clk);
      #1;
      rx_a = 1'b1;
      tick(2 * N);
      $display("break: frame_errs=%0d idle_cycles_while_low=%0d", a_frame_n - s_frame, nlow);
      chk("break_frame_err", a_frame_n - s_frame, 1);
      chk("break_frame_pos", a_frame_cyc - fall, 139);
      chk("break_busy_held", nlow, 0);
      chk("break_busy_released", int'(a_busy), 0);
      chk("break_no_valid", a_rise_n - s_rise, 0);
      send_a(7'h11, 1'b1, fall);
      tick(3 * N);
      $display("after break: data=%h", a_rise_data);
      chk("after_break_valid", a_rise_n - s_rise, 1);
      chk("after_break_latency", a_rise_cyc - fall, 139);
      chk("after_break_data", int'(a_rise_data), 'h11);

      // Overrun: two back-to-back words with nobody reading
      rdy_a = 1'b0;
      snap();
      send_a(7'h0F, 1'b1, f1);
      send_a(7'h70, 1'b1, f2);
      tick(3 * N);
      $display("overrun: data=%h valid=%b overruns=%0d", a_data, a_valid, a_ovr_n - s_ovr);
      chk("ovr_first_latency", a_rise_cyc - f1, 139);
      chk("ovr_pulse_count", a_ovr_n - s_ovr, 1);
      chk("ovr_pulse_pos", a_ovr_cyc - f2, 139);
      chk("ovr_data", int'(a_data), 'h70);
      chk("ovr_valid_held", int'(a_valid), 1);
      rdy_a = 1'b1;
      tick(1);
      rdy_a = 1'b0;
      chk("ovr_valid_cleared", int'(a_valid), 0);

      // Acceptance in the completion cycle of the second word: no overrun
      snap();
      send_a(7'h0F, 1'b1, f1);
      fork
         send_a(7'h70, 1'b1, f2);
         begin
            tick(138);
            rdy_a = 1'b1;
            tick(1);
            rdy_a = 1'b0;
         end
      join
      tick(3 * N);
      $display("accept+load: data=%h valid=%b overruns=%0d", a_data, a_valid, a_ovr_n - s_ovr);
      chk("acc_no_overrun", a_ovr_n - s_ovr, 0);
      chk("acc_valid_held", int'(a_valid), 1);
      chk("acc_data", int'(a_data), 'h70);
      rdy_a = 1'b1;
      tick(2);

      // Odd parity instance
      snap();
      send_p(7'h01, 1'b0, 1'b1, fall);
      tick(3 * N);
      $display("parity ok: data=%h", p_rise_data);
      chk("par_ok_valid", p_rise_n - sp_rise, 1);
      chk("par_ok_latency", p_rise_cyc - fall, 155);
      chk("par_ok_data", int'(p_rise_data), 'h01);
      chk("par_ok_no_err", p_par_n - sp_par, 0);
      snap();
      send_p(7'h01, 1'b1, 1'b1, fall);
      tick(3 * N);
      $display("parity bad: parity_errs=%0d", p_par_n - sp_par);
      chk("par_bad_err", p_par_n - sp_par, 1);
      chk("par_bad_pos", p_par_cyc - fall, 155);
      chk("par_bad_no_valid", p_rise_n - sp_rise, 0);
      chk("par_bad_no_frame", p_frame_n - sp_frame, 0);
      snap();
      send_p(7'h01, 1'b1, 1'b0, fall);
      tick(3 * N);
      $display("parity+stop bad: frame_errs=%0d parity_errs=%0d", p_frame_n - sp_frame, p_par_n - sp_par);
      chk("both_frame_err", p_frame_n - sp_frame, 1);
      chk("both_no_parity_err", p_par_n - sp_par, 0);
      chk("both_no_valid", p_rise_n - sp_rise, 0);
      chk("par_no_overrun", p_ovr_n - sp_ovr, 0);

      // Reset during data bit 3, then a clean frame
      snap();
      fork
         send_a(7'h7F, 1'b1, fall);
         begin
            tick(70);
            rst_n = 1'b0;
            tick(1);
            chk("midreset_outputs", int'({a_valid, a_frame, a_par, a_ovr, a_busy, a_data}), 0);
            rst_n = 1'b1;
         end
      join
      tick(3 * N);
      $display("mid-frame reset: valid_rises=%0d busy=%b", a_rise_n - s_rise, a_busy);
      chk("midreset_no_valid", a_rise_n - s_rise, 0);
      chk("midreset_no_frame", a_frame_n - s_frame, 0);
      chk("midreset_idle", int'(a_busy), 0);
      send_a(7'h2C, 1'b1, fall);
      tick(3 * N);
      $display("post-reset: data=%h", a_rise_data);
      chk("post_reset_valid", a_rise_n - s_rise, 1);
      chk("post_reset_latency", a_rise_cyc - fall, 139);
      chk("post_reset_data", int'(a_rise_data), 'h2C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
